// File: rtl/panel_event_port.sv
// Generic first-word-fall-through FIFO; storage is cleared on reset.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: writes are ignored while full; rd_rdy pops the head while rd_vld.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full   = (count == FULL_CNT);
    assign rd_vld = (count != '0);
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Panel endpoint: synchronize + debounce buttons into an edge-event stream, hold the LED register.
// Latency: button change to event head is DEBOUNCE+3 cycles on an idle FIFO; leds load 1 cycle after led_wr.
// Backpressure: head holds while evt_ready is low; edges wait in pending bits, a repeated edge sets overflow.
module panel_event_port #(
    parameter int WIDTH      = 8,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         buttons,
    output logic [WIDTH-1:0]         leds,
    input  logic                     led_wr,
    input  logic [WIDTH-1:0]         led_wdata,
    output logic [WIDTH-1:0]         btn_state,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(WIDTH)-1:0] evt_index,
    output logic                     evt_pressed,
    output logic                     overflow
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef struct packed {
        logic [IW-1:0] index;
        logic          pressed;
    } evt_t;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] push_mask;
    logic [CW-1:0]    cnt [WIDTH];
    logic             push_vld;
    logic             fifo_full;
    logic [IW-1:0]    push_idx;
    evt_t             push_evt;
    evt_t             head_evt;

    // A bit commits on the cycle its counter would reach DEBOUNCE.
    always_comb begin
        commit = '0;
        for (int i = 0; i < WIDTH; i++)
            commit[i] = (s2[i] != btn_state[i]) && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            btn_state <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1        <= buttons;
            s2        <= s1;
            btn_state <= btn_state ^ commit;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == btn_state[i]) || commit[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Lowest-index pending bit wins; gated by the registered (pre-pop) FIFO count.
    always_comb begin
        push_idx  = '0;
        push_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (pending[i]) push_idx = IW'(i);
        push_vld = (|pending) && !fifo_full;
        if (push_vld) push_mask[push_idx] = 1'b1;
        push_evt.index   = push_idx;
        push_evt.pressed = btn_state[push_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
            leds     <= '0;
        end else begin
            pending  <= (pending & ~push_mask) | commit;
            overflow <= overflow | (|(commit & pending & ~push_mask));
            if (led_wr) leds <= led_wdata;
        end
    end

    fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_dat (push_evt),
        .full   (fifo_full),
        .rd_vld (evt_valid),
        .rd_rdy (evt_ready),
        .rd_dat (head_evt)
    );

    assign evt_index   = head_evt.index;
    assign evt_pressed = head_evt.pressed;
endmodule

// File: tb/tb_panel_event_port.sv
// Bench for panel_event_port: directed scenarios against fixed expectations, then random
// traffic against a queue-based reference model stepped on every clock edge.
module tb_panel_event_port;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int FD = 4;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  buttons = '0;
    logic [W-1:0]  led_wdata = '0;
    logic          led_wr = 1'b0;
    logic          evt_ready = 1'b0;
    logic [W-1:0]  leds;
    logic [W-1:0]  btn_state;
    logic          evt_valid;
    logic [IW-1:0] evt_index;
    logic          evt_pressed;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    panel_event_port #(.WIDTH(W), .DEBOUNCE(D), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons     (buttons),
        .leds        (leds),
        .led_wr      (led_wr),
        .led_wdata   (led_wdata),
        .btn_state   (btn_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_index   (evt_index),
        .evt_pressed (evt_pressed),
        .overflow    (overflow)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          pr;
    } ev_t;

    // Reference model: level history, pending set and a bounded event queue.
    logic [W-1:0] m_s1, m_s2, m_state, m_pend, m_leds;
    logic         m_ovf;
    logic [W-1:0] m_hist[$];
    ev_t          m_fifo[$];

    task automatic model_update();
        logic [W-1:0] cm;
        bit           room;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0; m_leds = '0; m_ovf = 1'b0;
            m_hist.delete();
            m_fifo.delete();
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            cm = '0;
            if (m_hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][i] == m_state[i]) all_diff = 1'b0;
                    cm[i] = all_diff;
                end
            end
            room = (m_fifo.size() < FD);
            if (evt_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (room) begin
                for (int i = 0; i < W; i++) begin
                    if (m_pend[i]) begin
                        ev_t e;
                        e.idx = IW'(i);
                        e.pr  = m_state[i];
                        m_fifo.push_back(e);
                        m_pend[i] = 1'b0;
                        break;
                    end
                end
            end
            for (int i = 0; i < W; i++) begin
                if (cm[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            m_state = m_state ^ cm;
            if (led_wr) m_leds = led_wdata;
            m_s2 = m_s1;
            m_s1 = buttons;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; buttons = '0; evt_ready = 1'b0; led_wr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; buttons = '0;
        repeat (3) tick();
        n_checks++; if (leds !== 8'h00) $display("FAIL rst_leds got %h want 00", leds); else n_pass++;
        n_checks++; if (btn_state !== 8'h00) $display("FAIL rst_state got %h want 00", btn_state); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_index !== 3'd0) $display("FAIL rst_index got %0d want 0", evt_index); else n_pass++;
        n_checks++; if (evt_pressed !== 1'b0) $display("FAIL rst_pressed got %b want 0", evt_pressed); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_led();
        led_wr = 1'b1; led_wdata = 8'hA5;
        tick();
        led_wr = 1'b0; led_wdata = 8'h3C;
        n_checks++; if (leds !== 8'hA5) $display("FAIL led_load got %h want a5", leds); else n_pass++;
        repeat (3) tick();
        n_checks++; if (leds !== 8'hA5) $display("FAIL led_hold got %h want a5", leds); else n_pass++;
    endtask

    task automatic test_single_press();
        logic [W-1:0] exp_s;
        apply_reset();
        evt_ready = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            buttons = (phase == 0) ? 8'h04 : 8'h00;
            for (int k = 1; k <= 10; k++) begin
                tick();
                exp_s = ((k >= 6) == (phase == 0)) ? 8'h04 : 8'h00;
                n_checks++; if (btn_state !== exp_s) $display("FAIL sp_state k=%0d got %h want %h", k, btn_state, exp_s); else n_pass++;
                n_checks++; if (evt_valid !== (k == 7)) $display("FAIL sp_valid k=%0d got %b want %b", k, evt_valid, (k == 7)); else n_pass++;
                if (k == 7) begin
                    n_checks++; if (evt_index !== 3'd2) $display("FAIL sp_index got %0d want 2", evt_index); else n_pass++;
                    n_checks++; if (evt_pressed !== (phase == 0)) $display("FAIL sp_pressed got %b want %b", evt_pressed, (phase == 0)); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        evt_ready = 1'b1;
        buttons = 8'h20;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 3) buttons = 8'h00;
            n_checks++; if (evt_valid !== 1'b0) $display("FAIL gl_valid k=%0d got %b want 0", k, evt_valid); else n_pass++;
            n_checks++; if (btn_state !== 8'h00) $display("FAIL gl_state k=%0d got %h want 00", k, btn_state); else n_pass++;
        end
        n_checks++; if (overflow !== 1'b0) $display("FAIL gl_ovf got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        evt_ready = 1'b1;
        buttons = 8'h81;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++; if (evt_valid !== (k == 7 || k == 8)) $display("FAIL sim_valid k=%0d got %b", k, evt_valid); else n_pass++;
            if (k == 7 || k == 8) begin
                n_checks++; if (evt_index !== ((k == 7) ? 3'd0 : 3'd7)) $display("FAIL sim_index k=%0d got %0d", k, evt_index); else n_pass++;
                n_checks++; if (evt_pressed !== 1'b1) $display("FAIL sim_pressed k=%0d got %b want 1", k, evt_pressed); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        apply_reset();
        for (int b = 0; b < 6; b++) begin
            buttons[b] = 1'b1;
            repeat (10) tick();
            n_checks++; if (evt_valid !== 1'b1) $display("FAIL bp_valid b=%0d got %b want 1", b, evt_valid); else n_pass++;
            n_checks++; if (evt_index !== 3'd0) $display("FAIL bp_head b=%0d got %0d want 0", b, evt_index); else n_pass++;
            n_checks++; if (evt_pressed !== 1'b1) $display("FAIL bp_head_pr b=%0d got %b want 1", b, evt_pressed); else n_pass++;
        end
        n_checks++; if (btn_state !== 8'h3F) $display("FAIL bp_state got %h want 3f", btn_state); else n_pass++;
        evt_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (evt_valid) begin
                n_checks++; if (evt_index !== IW'(got) || evt_pressed !== 1'b1)
                    $display("FAIL bp_drain n=%0d got %0d/%b want %0d/1", got, evt_index, evt_pressed, got); else n_pass++;
                got++;
            end
            tick();
        end
        n_checks++; if (got !== 6) $display("FAIL bp_count got %0d want 6", got); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL bp_ovf got %b want 0", overflow); else n_pass++;
        buttons = '0;
        repeat (20) tick();
    endtask

    task automatic test_merged_edge();
        int   exp_i [5] = '{0, 1, 2, 4, 3};
        logic exp_p [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ev_t  got[$];
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            buttons[exp_i[j]] = 1'b1;
            repeat (10) tick();
        end
        buttons[3] = 1'b1;
        repeat (10) tick();
        n_checks++; if (overflow !== 1'b0) $display("FAIL me_ovf_early got %b want 0", overflow); else n_pass++;
        buttons[3] = 1'b0;
        repeat (10) tick();
        n_checks++; if (overflow !== 1'b1) $display("FAIL me_ovf got %b want 1", overflow); else n_pass++;
        n_checks++; if (btn_state !== 8'h17) $display("FAIL me_state got %h want 17", btn_state); else n_pass++;
        evt_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (evt_valid) begin
                ev_t e;
                e.idx = evt_index;
                e.pr  = evt_pressed;
                got.push_back(e);
            end
            tick();
        end
        n_checks++; if (got.size() != 5) $display("FAIL me_count got %0d want 5", got.size()); else n_pass++;
        for (int j = 0; j < 5; j++) begin
            if (j < got.size()) begin
                n_checks++; if (got[j].idx !== IW'(exp_i[j]) || got[j].pr !== exp_p[j])
                    $display("FAIL me_evt n=%0d got %0d/%b want %0d/%b", j, got[j].idx, got[j].pr, exp_i[j], exp_p[j]); else n_pass++;
            end
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL me_ovf_sticky got %b want 1", overflow); else n_pass++;
        apply_reset();
        n_checks++; if (overflow !== 1'b0) $display("FAIL me_ovf_clear got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        buttons = 8'h10;
        repeat (10) tick();
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL rm_pre_valid got %b want 1", evt_valid); else n_pass++;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL rm_flush got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (btn_state !== 8'h00) $display("FAIL rm_state got %h want 00", btn_state); else n_pass++;
        n_checks++; if ({evt_index, evt_pressed} !== 4'h0) $display("FAIL rm_head got %0d/%b want 0/0", evt_index, evt_pressed); else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++; if (evt_valid !== (k >= 7)) $display("FAIL rm_valid k=%0d got %b", k, evt_valid); else n_pass++;
        end
        n_checks++; if (evt_index !== 3'd4 || evt_pressed !== 1'b1) $display("FAIL rm_evt got %0d/%b want 4/1", evt_index, evt_pressed); else n_pass++;
    endtask

    task automatic test_random();
        int b;
        int mode;
        apply_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            mode = (cyc / 150) % 3;
            case (mode)
                0:       evt_ready = 1'b1;
                1:       evt_ready = 1'($urandom_range(0, 1));
                default: evt_ready = ($urandom_range(0, 15) == 0);
            endcase
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, W - 1);
                buttons[b] = ~buttons[b];
            end
            led_wr    = ($urandom_range(0, 7) == 0);
            led_wdata = W'($urandom);
            rst       = (cyc == 2000 || cyc == 2001);
            tick();
            n_checks++; if (btn_state !== m_state) $display("FAIL rnd_state c=%0d got %h want %h", cyc, btn_state, m_state); else n_pass++;
            n_checks++; if (evt_valid !== (m_fifo.size() != 0)) $display("FAIL rnd_valid c=%0d got %b want %b", cyc, evt_valid, (m_fifo.size() != 0)); else n_pass++;
            if (m_fifo.size() != 0) begin
                n_checks++; if ({evt_index, evt_pressed} !== m_fifo[0])
                    $display("FAIL rnd_head c=%0d got %0d/%b want %0d/%b", cyc, evt_index, evt_pressed, m_fifo[0].idx, m_fifo[0].pr); else n_pass++;
            end
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf c=%0d got %b want %b", cyc, overflow, m_ovf); else n_pass++;
            n_checks++; if (leds !== m_leds) $display("FAIL rnd_leds c=%0d got %h want %h", cyc, leds, m_leds); else n_pass++;
        end
        rst = 1'b0;
        led_wr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_led();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_backpressure();
        test_merged_edge();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
